// File: rtl/ram_loader_pkg.sv
// Shared types and defaults for the arithmetic-sequencer RAM loader.
package ram_loader_pkg;

  typedef enum logic [2:0] {
    S_OPND = 3'd0,
    S_OP   = 3'd1,
    S_CSUM = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [31:0] SENTINEL = 32'hFFFF_FFFF;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_OPND_BASE = 0;
  // Must match the opcode base hard-wired into the downstream controller.
  localparam int DEF_OP_BASE   = 100;
  localparam int DEF_MAX_OPND  = 100;
  localparam int DEF_MAX_OP    = 100;

endpackage

// File: rtl/ram_loader_if.sv
// Byte-stream input and RAM port-A write bus of the loader; master = loader side.
interface ram_loader_if #(
  parameter int ADDR_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_byte;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [31:0]       dina;

  modport master (
    input  in_valid, in_byte,
    output in_ready, wea, addra, dina
  );

  modport slave (
    output in_valid, in_byte,
    input  in_ready, wea, addra, dina
  );

endinterface

// File: rtl/ram_loader_byte_packer.sv
// Assembles accepted bytes into 32-bit big-endian words; word_valid pulses on the 4th byte.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        take,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_r;
  logic [23:0] shift_r;

  // Byte counter and shift register; partial words survive gaps in take.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= 2'd0;
      shift_r <= 24'd0;
    end else if (take) begin
      cnt_r   <= cnt_r + 2'd1;
      shift_r <= {shift_r[15:0], data};
    end
  end

  assign word_valid = take && (cnt_r == 2'd3);
  assign word       = {shift_r, data};

endmodule

// File: rtl/ram_loader.sv
// Loads operand and opcode lists into the shared RAM and releases the controller.
// Optional trailing checksum word enabled by defining RAM_LOADER_CHECKSUM_EN.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int OPND_BASE = DEF_OPND_BASE,
  parameter int OP_BASE   = DEF_OP_BASE,
  parameter int MAX_OPND  = DEF_MAX_OPND,
  parameter int MAX_OP    = DEF_MAX_OP
) (
  input  logic          clk,
  input  logic          rst,
  ram_loader_if.master  bus,
  output logic          ctrl_rst_n,
  output logic          done,
  output logic          err
);

  localparam int IDX_W = ADDR_W + 1;

  if ((OPND_BASE + MAX_OPND > OP_BASE) || (OP_BASE + MAX_OP > (1 << ADDR_W))) begin : g_param_bad
    $error("ram_loader: operand/opcode regions overlap or exceed the address space");
  end

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic               in_ready_r;
  logic               wea_r;
  logic [ADDR_W-1:0]  addra_r;
  logic [31:0]        dina_r;
  logic               ctrl_rst_n_r;
  logic               done_r;
  logic               err_r;
  logic               take_s;
  logic               word_valid_s;
  logic [31:0]        word_s;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic [31:0]        sum_r;
`endif

  assign take_s = bus.in_valid && in_ready_r;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .take       (take_s),
    .data       (bus.in_byte),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Load FSM: list bookkeeping, RAM write strobe and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_OPND;
      idx_r        <= '0;
      in_ready_r   <= 1'b1;
      wea_r        <= 1'b0;
      addra_r      <= '0;
      dina_r       <= 32'd0;
      ctrl_rst_n_r <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
      sum_r        <= 32'd0;
`endif
    end else begin
      wea_r <= 1'b0;
      if (word_valid_s) begin
        case (state_r)
          S_OPND: begin
            if (word_s == SENTINEL) begin
              wea_r   <= 1'b1;
              addra_r <= ADDR_W'(OPND_BASE) + idx_r[ADDR_W-1:0];
              dina_r  <= word_s;
              idx_r   <= '0;
              state_r <= S_OP;
            end else if (idx_r == IDX_W'(MAX_OPND - 1)) begin
              // Last slot is reserved for the sentinel.
              in_ready_r <= 1'b0;
              err_r      <= 1'b1;
              state_r    <= S_ERR;
            end else begin
              wea_r   <= 1'b1;
              addra_r <= ADDR_W'(OPND_BASE) + idx_r[ADDR_W-1:0];
              dina_r  <= word_s;
              idx_r   <= idx_r + IDX_W'(1);
`ifdef RAM_LOADER_CHECKSUM_EN
              sum_r   <= sum_r + word_s;
`endif
            end
          end
          S_OP: begin
            if (word_s == SENTINEL) begin
`ifdef RAM_LOADER_CHECKSUM_EN
              state_r      <= S_CSUM;
`else
              in_ready_r   <= 1'b0;
              done_r       <= 1'b1;
              ctrl_rst_n_r <= 1'b1;
              state_r      <= S_DONE;
`endif
            end else if (idx_r == IDX_W'(MAX_OP)) begin
              in_ready_r <= 1'b0;
              err_r      <= 1'b1;
              state_r    <= S_ERR;
            end else begin
              wea_r   <= 1'b1;
              addra_r <= ADDR_W'(OP_BASE) + idx_r[ADDR_W-1:0];
              dina_r  <= word_s;
              idx_r   <= idx_r + IDX_W'(1);
`ifdef RAM_LOADER_CHECKSUM_EN
              sum_r   <= sum_r + word_s;
`endif
            end
          end
`ifdef RAM_LOADER_CHECKSUM_EN
          S_CSUM: begin
            in_ready_r <= 1'b0;
            if (word_s == sum_r) begin
              done_r       <= 1'b1;
              ctrl_rst_n_r <= 1'b1;
              state_r      <= S_DONE;
            end else begin
              err_r   <= 1'b1;
              state_r <= S_ERR;
            end
          end
`endif
          default: begin
            in_ready_r <= 1'b0;
            err_r      <= 1'b1;
            state_r    <= S_ERR;
          end
        endcase
      end
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.wea      = wea_r;
  assign bus.addra    = addra_r;
  assign bus.dina     = dina_r;
  assign ctrl_rst_n   = ctrl_rst_n_r;
  assign done         = done_r;
  assign err          = err_r;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: records RAM writes and checks them against hand-computed lists.
module tb_ram_loader;
  import ram_loader_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ctrl_rst_n;
  logic done;
  logic err;

  int vectors     = 0;
  int miscompares = 0;
  int wide_cnt    = 0;
  bit wea_prev    = 1'b0;
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  ram_loader_if #(.ADDR_W(8)) bus ();

  ram_loader #(
    .ADDR_W(8), .OPND_BASE(0), .OP_BASE(100), .MAX_OPND(100), .MAX_OP(100)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ctrl_rst_n(ctrl_rst_n), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.wea === 1'b1) begin
      wr_addr.push_back(bus.addra);
      wr_data.push_back(bus.dina);
      if (wea_prev) wide_cnt++;
    end
    wea_prev = (bus.wea === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input int i, input logic [7:0] a, input logic [31:0] d);
    check($sformatf("wr%0d_addr", i), {24'd0, wr_addr[i]}, {24'd0, a});
    check($sformatf("wr%0d_data", i), wr_data[i], d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Leaves the 4th byte driven; the caller decides what follows.
  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (g) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_byte  = w[31-8*k -: 8];
    end
  endtask

  task automatic std_stream(input int gap, input logic [31:0] csum);
    send_word(32'h0000_0005, gap);
    send_word(32'h0000_0003, gap);
    send_word(SENTINEL, gap);
    send_word(32'h0000_0002, gap);
    send_word(SENTINEL, gap);
`ifdef RAM_LOADER_CHECKSUM_EN
    send_word(csum, gap);
`else
    if (csum == 32'd0) bus.in_valid = 1'b1;
`endif
  endtask

  task automatic check_std_run(input string tag);
    check({tag, "_done_early"}, {31'd0, done}, 32'd0);
    idle(1);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_ctrl_rst_n"}, {31'd0, ctrl_rst_n}, 32'd1);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    idle(3);
    #1;
    check({tag, "_nwr"}, wr_addr.size(), 32'd4);
    check_wr(0, 8'd0, 32'h0000_0005);
    check_wr(1, 8'd1, 32'h0000_0003);
    check_wr(2, 8'd2, 32'hFFFF_FFFF);
    check_wr(3, 8'd100, 32'h0000_0002);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;

    // Reset state while rst is held.
    repeat (2) @(negedge clk);
    check("rst_wea", {31'd0, bus.wea}, 32'd0);
    check("rst_addra", {24'd0, bus.addra}, 32'd0);
    check("rst_dina", bus.dina, 32'd0);
    check("rst_ctrl_rst_n", {31'd0, ctrl_rst_n}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    do_reset();

    // Back-to-back nominal stream.
    std_stream(0, 32'h0000_000A);
    check_std_run("b2b");

    // Same stream with random input gaps.
    do_reset();
    std_stream(5, 32'h0000_000A);
    check_std_run("gap");
    check("wea_width", wide_cnt, 32'd0);

    // Operand overflow: 101 non-sentinel words.
    do_reset();
    for (int i = 0; i < 101; i++) send_word(32'(i + 1), 0);
    idle(3);
    #1;
    check("ovf_nwr", wr_addr.size(), 32'd99);
    check_wr(0, 8'd0, 32'd1);
    check_wr(98, 8'd98, 32'd99);
    check("ovf_err", {31'd0, err}, 32'd1);
    check("ovf_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("ovf_ctrl_rst_n", {31'd0, ctrl_rst_n}, 32'd0);
    check("ovf_done", {31'd0, done}, 32'd0);

    // Operand sentinel in the last slot, then opcode overflow.
    do_reset();
    for (int i = 0; i < 99; i++) send_word(32'(100 + i), 0);
    send_word(SENTINEL, 0);
    for (int j = 0; j < 101; j++) send_word(32'(32'h1000 + j), 0);
    idle(3);
    #1;
    check("opovf_nwr", wr_addr.size(), 32'd200);
    check_wr(99, 8'd99, SENTINEL);
    check_wr(100, 8'd100, 32'h0000_1000);
    check_wr(199, 8'd199, 32'h0000_1063);
    check("opovf_err", {31'd0, err}, 32'd1);
    check("opovf_ctrl_rst_n", {31'd0, ctrl_rst_n}, 32'd0);

    // Empty opcode list.
    do_reset();
    send_word(SENTINEL, 0);
    send_word(SENTINEL, 0);
`ifdef RAM_LOADER_CHECKSUM_EN
    send_word(32'd0, 0);
`endif
    check("empty_done_early", {31'd0, done}, 32'd0);
    idle(1);
    check("empty_done", {31'd0, done}, 32'd1);
    check("empty_ctrl_rst_n", {31'd0, ctrl_rst_n}, 32'd1);
    idle(2);
    #1;
    check("empty_nwr", wr_addr.size(), 32'd1);
    check_wr(0, 8'd0, SENTINEL);

    // Reset in the middle of a word discards the partial bytes.
    do_reset();
    send_word(32'h0000_0005, 0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hAA;
    @(negedge clk);
    bus.in_byte  = 8'hBB;
    do_reset();
    send_word(32'h0000_0007, 0);
    send_word(SENTINEL, 0);
    send_word(SENTINEL, 0);
`ifdef RAM_LOADER_CHECKSUM_EN
    send_word(32'h0000_0007, 0);
`endif
    idle(3);
    #1;
    check("mid_nwr", wr_addr.size(), 32'd2);
    check_wr(0, 8'd0, 32'h0000_0007);
    check_wr(1, 8'd1, SENTINEL);
    check("mid_done", {31'd0, done}, 32'd1);

`ifdef RAM_LOADER_CHECKSUM_EN
    // Wrong checksum.
    do_reset();
    std_stream(0, 32'h0000_000B);
    idle(3);
    #1;
    check("csum_err", {31'd0, err}, 32'd1);
    check("csum_done", {31'd0, done}, 32'd0);
    check("csum_ctrl_rst_n", {31'd0, ctrl_rst_n}, 32'd0);
    check("csum_nwr", wr_addr.size(), 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
